// File: rtl/kbd_pkg.sv
// Shared constants, event layout and handshake states for the keyboard
// event controller.
package kbd_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef struct packed {
    logic       lost;
    logic       rsvd;
    logic       caps;
    logic       alt;
    logic       ctrl;
    logic       shift;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } kbd_event_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/kbd_event_fifo.sv
// Show-ahead synchronous FIFO. A push into a full FIFO is accepted only when
// a pop frees a slot in the same cycle; otherwise it is reported as dropped.
module kbd_event_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dropped = push & ~do_push;
  assign count   = cnt;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; empty-gating of rd_data hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/kbd_event_ctrl.sv
// Pops bytes from the PS/2 receiver, decodes prefixes into key events with
// modifier/caps state, and queues them for the CPU side.
module kbd_event_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH      = 16,
  parameter int SUPPRESS_REPEAT = 1,
  parameter int E1_SKIP         = 7
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_ready,
  input  logic                          rx_overflow,
  output logic                          rx_nextdata_n,
  output logic                          ev_valid,
  output logic [15:0]                   ev_data,
  input  logic                          ev_pop,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic [7:0]                    drop_cnt
);

  localparam logic [7:0] SKIP_INIT = 8'(E1_SKIP);

  rx_state_t    state_q, state_d;
  logic [7:0]   byte_q, byte_d;
  logic         pend_ext_q, ext_d;
  logic         pend_brk_q, brk_d;
  logic [7:0]   skip_q, skip_d;
  logic [511:0] held_q, held_d;
  logic         caps_q, caps_d;
  logic         lost_q;
  logic [8:0]   key_idx;
  logic         push;
  logic         fifo_empty;
  logic         fifo_full;
  logic         fifo_dropped;
  kbd_event_t   ev;

  assign rx_nextdata_n = (state_q != POP);
  assign ev_valid      = ~fifo_empty;
  assign key_idx       = {pend_ext_q, byte_q};

  // NOTE: every always_comb output gets its default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    ext_d   = pend_ext_q;
    brk_d   = pend_brk_q;
    skip_d  = skip_q;
    held_d  = held_q;
    caps_d  = caps_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_ready) begin
          byte_d  = rx_data;
          state_d = POP;
        end
      end
      POP: begin
        state_d = GAP;
        if (skip_q != 8'd0) begin
          skip_d = skip_q - 8'd1;
        end else if (byte_q == SC_E1) begin
          skip_d = SKIP_INIT;
          ext_d  = 1'b0;
          brk_d  = 1'b0;
        end else if (byte_q == SC_E0) begin
          ext_d = 1'b1;
        end else if (byte_q == SC_F0) begin
          brk_d = 1'b1;
        end else begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          // A make of an already-held key is a typematic repeat.
          if (pend_brk_q || (SUPPRESS_REPEAT == 0) || !held_q[key_idx]) begin
            push            = 1'b1;
            held_d[key_idx] = ~pend_brk_q;
            if (!pend_brk_q && key_idx == {1'b0, SC_CAPS}) caps_d = ~caps_q;
          end
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rx_overflow) begin
      ext_d  = 1'b0;
      brk_d  = 1'b0;
      skip_d = 8'd0;
    end
  end

  // Modifiers come from the post-update bitmap so the event reflects itself.
  always_comb begin
    ev       = '0;
    ev.code  = byte_q;
    ev.ext   = pend_ext_q;
    ev.brk   = pend_brk_q;
    ev.shift = held_d[{1'b0, SC_LSHIFT}] | held_d[{1'b0, SC_RSHIFT}];
    ev.ctrl  = held_d[{1'b0, SC_CTRL}]   | held_d[{1'b1, SC_CTRL}];
    ev.alt   = held_d[{1'b0, SC_ALT}]    | held_d[{1'b1, SC_ALT}];
    ev.caps  = caps_d;
    ev.lost  = lost_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      byte_q     <= '0;
      pend_ext_q <= 1'b0;
      pend_brk_q <= 1'b0;
      skip_q     <= '0;
      held_q     <= '0;
      caps_q     <= 1'b0;
      lost_q     <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      pend_ext_q <= ext_d;
      pend_brk_q <= brk_d;
      skip_q     <= skip_d;
      held_q     <= held_d;
      caps_q     <= caps_d;
      if (rx_overflow || fifo_dropped) lost_q <= 1'b1;
      else if (push)                   lost_q <= 1'b0;
      if (fifo_dropped && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  kbd_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .clrn      (clrn),
    .push      (push),
    .push_data (ev),
    .pop       (ev_pop),
    .rd_data   (ev_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (ev_count),
    .dropped   (fifo_dropped)
  );

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Self-checking bench for kbd_event_ctrl: directed scenarios plus a random
// byte stream checked against a queue-based scan-code model.
module tb_kbd_event_ctrl;

  localparam int DEPTH = 4;
  localparam int SKIP  = 7;

  logic        clk = 1'b0;
  logic        clrn;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_overflow;
  logic        rx_nextdata_n;
  logic        ev_valid;
  logic [15:0] ev_data;
  logic        ev_pop;
  logic [2:0]  ev_count;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  kbd_event_ctrl #(
    .FIFO_DEPTH      (DEPTH),
    .SUPPRESS_REPEAT (1),
    .E1_SKIP         (SKIP)
  ) dut (
    .clk           (clk),
    .clrn          (clrn),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .rx_overflow   (rx_overflow),
    .rx_nextdata_n (rx_nextdata_n),
    .ev_valid      (ev_valid),
    .ev_data       (ev_data),
    .ev_pop        (ev_pop),
    .ev_count      (ev_count),
    .drop_cnt      (drop_cnt)
  );

  // Reference model: scan-code rules applied byte by byte.
  bit          m_held[512];
  int          m_skip;
  bit          m_ext, m_brk, m_caps, m_lost;
  int          m_drop;
  logic [15:0] mq[$];

  function automatic void model_reset();
    foreach (m_held[i]) m_held[i] = 1'b0;
    m_skip = 0; m_ext = 0; m_brk = 0; m_caps = 0; m_lost = 0; m_drop = 0;
    mq.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int idx;
    logic [15:0] e;
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = SKIP; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      idx = (m_ext ? 256 : 0) + int'(b);
      if (m_brk || !m_held[idx]) begin
        m_held[idx] = !m_brk;
        if (!m_brk && idx == 'h58) m_caps = !m_caps;
        e      = 16'h0;
        e[7:0] = b;
        e[8]   = m_ext;
        e[9]   = m_brk;
        e[10]  = m_held['h12] | m_held['h59];
        e[11]  = m_held['h14] | m_held['h114];
        e[12]  = m_held['h11] | m_held['h111];
        e[13]  = m_caps;
        if (mq.size() < DEPTH) begin
          e[15] = m_lost;
          m_lost = 0;
          mq.push_back(e);
        end else begin
          if (m_drop < 255) m_drop++;
          m_lost = 1;
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endfunction

  task automatic do_reset();
    rx_ready = 0; rx_overflow = 0; ev_pop = 0; rx_data = 8'h00;
    #3 clrn = 0;
    repeat (2) @(negedge clk);
    clrn = 1;
    model_reset();
  endtask

  // Presents one byte to the DUT and waits for its pop strobe; optionally
  // pops the event FIFO in the same cycle the byte is decoded.
  task automatic send_byte(input logic [7:0] b, input bit pop_too);
    bit got = 0;
    @(negedge clk);
    rx_data = b; rx_ready = 1;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (rx_nextdata_n === 1'b0) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL pop_strobe byte=%h: rx_nextdata_n=%b, required a low strobe", b, rx_nextdata_n);
      rx_ready = 0;
      return;
    end
    rx_ready = 0;
    if (pop_too) begin
      ev_pop = 1;
      if (mq.size() > 0) begin
        n_cmp++;
        if (ev_data !== mq[0]) begin
          n_bad++;
          $display("FAIL same_cycle_pop: ev_data=%h required %h", ev_data, mq[0]);
        end
        void'(mq.pop_front());
      end
    end
    model_byte(b);
    @(negedge clk);
    ev_pop = 0;
    n_cmp++;
    if (rx_nextdata_n !== 1'b1) begin
      n_bad++;
      $display("FAIL strobe_width byte=%h: rx_nextdata_n=%b required 1", b, rx_nextdata_n);
    end
  endtask

  task automatic pop_expect(input logic [15:0] exp, input string name);
    @(negedge clk);
    n_cmp++;
    if (ev_valid !== 1'b1 || ev_data !== exp) begin
      n_bad++;
      $display("FAIL %s: ev_valid=%b ev_data=%h required valid=1 data=%h", name, ev_valid, ev_data, exp);
    end
    ev_pop = 1;
    @(negedge clk);
    ev_pop = 0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic test_reset();
    rx_ready = 0; rx_overflow = 0; ev_pop = 0; rx_data = 8'h00;
    clrn = 0;
    #12;
    n_cmp++;
    if (rx_nextdata_n !== 1'b1 || ev_valid !== 1'b0 || ev_data !== 16'h0 ||
        ev_count !== 3'd0 || drop_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_state: nd_n=%b valid=%b data=%h count=%0d drop=%0d required 1 0 0000 0 0",
               rx_nextdata_n, ev_valid, ev_data, ev_count, drop_cnt);
    end
    @(negedge clk);
    clrn = 1;
    model_reset();
  endtask

  task automatic test_basic();
    do_reset();
    send_byte(8'h1C, 0);
    n_cmp++;
    if (ev_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL latency: ev_valid=%b required 1 two clocks after rx_ready", ev_valid);
    end
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 0);
    n_cmp++;
    if (ev_count !== 3'd2) begin
      n_bad++;
      $display("FAIL basic_count: ev_count=%0d required 2", ev_count);
    end
    pop_expect(16'h001C, "basic_make");
    pop_expect(16'h021C, "basic_break");
    // Pop on an empty FIFO in the push cycle: the push still lands.
    send_byte(8'h2A, 1);
    n_cmp++;
    if (ev_count !== 3'd1 || ev_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL empty_push_pop: ev_count=%0d valid=%b required 1 1", ev_count, ev_valid);
    end
    pop_expect(16'h002A, "empty_push_pop_data");
  endtask

  task automatic test_modifiers();
    logic [7:0] seq[] = '{8'h12, 8'h1C, 8'hF0, 8'h12};
    do_reset();
    foreach (seq[i]) send_byte(seq[i], 0);
    pop_expect(16'h0412, "lshift_make");
    pop_expect(16'h041C, "shifted_key");
    pop_expect(16'h0212, "lshift_break");
    seq = '{8'hE0, 8'h14, 8'hE0, 8'hF0, 8'h14};
    foreach (seq[i]) send_byte(seq[i], 0);
    pop_expect(16'h0914, "rctrl_make");
    pop_expect(16'h0314, "rctrl_break");
    seq = '{8'h58, 8'hF0, 8'h58};
    foreach (seq[i]) send_byte(seq[i], 0);
    pop_expect(16'h2058, "caps_make");
    pop_expect(16'h2258, "caps_break_persist");
  endtask

  task automatic test_suppress();
    logic [7:0] seq[] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    do_reset();
    foreach (seq[i]) send_byte(seq[i], 0);
    n_cmp++;
    if (ev_count !== 3'd2) begin
      n_bad++;
      $display("FAIL suppress_count: ev_count=%0d required 2", ev_count);
    end
    pop_expect(16'h001C, "suppress_first");
    pop_expect(16'h021C, "suppress_break");
  endtask

  task automatic test_pause();
    logic [7:0] seq[] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
    do_reset();
    foreach (seq[i]) send_byte(seq[i], 0);
    n_cmp++;
    if (ev_count !== 3'd1) begin
      n_bad++;
      $display("FAIL pause_count: ev_count=%0d required 1", ev_count);
    end
    pop_expect(16'h001C, "pause_then_key");
  endtask

  task automatic test_fifo_full();
    logic [7:0] seq[] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33};
    do_reset();
    foreach (seq[i]) send_byte(seq[i], 0);
    n_cmp++;
    if (ev_count !== 3'd4 || drop_cnt !== 8'd2) begin
      n_bad++;
      $display("FAIL full_drop: ev_count=%0d drop_cnt=%0d required 4 2", ev_count, drop_cnt);
    end
    pop_expect(16'h001C, "full_head");
    send_byte(8'h2A, 0);
    // Full FIFO with simultaneous pop: both happen, nothing dropped.
    send_byte(8'h3B, 1);
    n_cmp++;
    if (ev_count !== 3'd4 || drop_cnt !== 8'd2) begin
      n_bad++;
      $display("FAIL full_push_pop: ev_count=%0d drop_cnt=%0d required 4 2", ev_count, drop_cnt);
    end
    pop_expect(16'h0023, "full_order_a");
    pop_expect(16'h002B, "full_order_b");
    pop_expect(16'h802A, "lost_flag");
    pop_expect(16'h003B, "lost_cleared");
  endtask

  task automatic test_rx_overflow();
    do_reset();
    send_byte(8'hE0, 0);
    @(negedge clk); rx_overflow = 1;
    @(negedge clk); rx_overflow = 0;
    m_lost = 1; m_ext = 0; m_brk = 0; m_skip = 0;
    send_byte(8'h1C, 0);
    pop_expect(16'h801C, "rx_overflow_lost");
  endtask

  task automatic test_drop_saturate();
    do_reset();
    for (int i = 0; i < 140; i++) begin
      send_byte(8'h1C, 0);
      send_byte(8'hF0, 0);
      send_byte(8'h1C, 0);
    end
    n_cmp++;
    if (drop_cnt !== 8'd255 || ev_count !== 3'd4) begin
      n_bad++;
      $display("FAIL drop_saturate: drop_cnt=%0d ev_count=%0d required 255 4", drop_cnt, ev_count);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_byte(8'h1C, 0);
    send_byte(8'hE0, 0);
    @(posedge clk);
    #2 clrn = 0;
    #1;
    n_cmp++;
    if (rx_nextdata_n !== 1'b1 || ev_valid !== 1'b0 || ev_data !== 16'h0 ||
        ev_count !== 3'd0 || drop_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL mid_reset: nd_n=%b valid=%b data=%h count=%0d drop=%0d required 1 0 0000 0 0",
               rx_nextdata_n, ev_valid, ev_data, ev_count, drop_cnt);
    end
    @(negedge clk);
    clrn = 1;
    model_reset();
    send_byte(8'h1C, 0);
    pop_expect(16'h001C, "mid_reset_prefix_gone");
  endtask

  task automatic test_random();
    logic [7:0] pool[] = '{8'hE0, 8'hF0, 8'hE1, 8'h1C, 8'h12, 8'h59, 8'h14,
                           8'h11, 8'h58, 8'h2A, 8'hF0, 8'h1C};
    int r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 65) begin
        send_byte(pool[$urandom_range(0, pool.size() - 1)], ($urandom_range(0, 3) == 0));
      end else if (r < 95) begin
        if (mq.size() > 0) begin
          pop_expect(mq[0], "random_pop");
        end else begin
          @(negedge clk); ev_pop = 1;
          @(negedge clk); ev_pop = 0;
        end
      end else begin
        @(negedge clk); rx_overflow = 1;
        @(negedge clk); rx_overflow = 0;
        m_lost = 1; m_ext = 0; m_brk = 0; m_skip = 0;
      end
      n_cmp++;
      if (ev_count !== 3'(mq.size()) || drop_cnt !== 8'(m_drop) ||
          ev_valid !== (mq.size() > 0)) begin
        n_bad++;
        $display("FAIL random_status step %0d: count=%0d drop=%0d valid=%b required %0d %0d %b",
                 i, ev_count, drop_cnt, ev_valid, mq.size(), m_drop, (mq.size() > 0));
      end
    end
    while (mq.size() > 0) pop_expect(mq[0], "random_drain");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modifiers();
    test_suppress();
    test_pause();
    test_fifo_full();
    test_rx_overflow();
    test_drop_saturate();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
